// File: rtl/qk_pkg.sv
// Shared types and score conversion helpers for the Q·Kᵀ score engine.
package qk_pkg;

   localparam int unsigned QK_DATA_WIDTH = 16;
   localparam int unsigned SAT_IN_WIDTH  = 64;

   localparam logic signed [QK_DATA_WIDTH-1:0] MIN_SCORE = {1'b1, {(QK_DATA_WIDTH-1){1'b0}}};
   localparam logic signed [QK_DATA_WIDTH-1:0] MAX_SCORE = {1'b0, {(QK_DATA_WIDTH-1){1'b1}}};

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      MAC,
      DRAIN,
      OUT,
      DONE
   } state_t;

   // Scale by arithmetic shift, then clamp into the signed score range.
   function automatic logic signed [QK_DATA_WIDTH-1:0] sat_to_data(
      input logic signed [SAT_IN_WIDTH-1:0] i_sum,
      input int unsigned                    i_shift
   );
      logic signed [SAT_IN_WIDTH-1:0] w_s;
      w_s = i_sum >>> i_shift;
      if (w_s > SAT_IN_WIDTH'(MAX_SCORE)) begin
         return MAX_SCORE;
      end else if (w_s < SAT_IN_WIDTH'(MIN_SCORE)) begin
         return MIN_SCORE;
      end else begin
         return QK_DATA_WIDTH'(w_s);
      end
   endfunction

endpackage

// File: rtl/qk_score_engine_if.sv
// K-row intake and score-group output handshakes of the score engine.
interface qk_score_engine_if #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned EMBED_DIM  = 64,
   parameter int unsigned LANES      = 4,
   parameter int unsigned SEQ_LEN    = 64
);
   localparam int unsigned IDX_W = $clog2(SEQ_LEN);

   logic                            k_valid;
   logic                            k_ready;
   logic [DATA_WIDTH*EMBED_DIM-1:0] k_row;

   logic                            score_valid;
   logic                            score_ready;
   logic [LANES*DATA_WIDTH-1:0]     score_data;
   logic [IDX_W-1:0]                score_row;
   logic [IDX_W-1:0]                score_col;

   modport slave (
      input  k_valid, k_row, score_ready,
      output k_ready, score_valid, score_data, score_row, score_col
   );

   modport master (
      output k_valid, k_row, score_ready,
      input  k_ready, score_valid, score_data, score_row, score_col
   );

endinterface

// File: rtl/qk_mac_lane.sv
// One dot-product lane: registered signed multiply, fixed-point rescale, accumulate.
module qk_mac_lane #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned FRAC_BITS  = 14,
   parameter int unsigned ACC_WIDTH  = 40
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_en,
   input  logic                         i_clr,
   input  logic signed [DATA_WIDTH-1:0] i_q,
   input  logic signed [DATA_WIDTH-1:0] i_k,
   output logic signed [ACC_WIDTH-1:0]  o_acc
);
   localparam int unsigned PROD_W = 2 * DATA_WIDTH;

   logic signed [PROD_W-1:0]    r_prod;
   logic                        r_prod_vld;
   logic                        r_prod_clr;
   logic signed [ACC_WIDTH-1:0] r_acc;
   logic signed [PROD_W-1:0]    w_prod_sh;
   logic signed [ACC_WIDTH-1:0] w_prod_ext;

   assign w_prod_sh  = r_prod >>> FRAC_BITS;
   assign w_prod_ext = ACC_WIDTH'(w_prod_sh);
   assign o_acc      = r_acc;

   // Clear flag travels with its product so the first element overwrites the sum.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prod     <= '0;
         r_prod_vld <= 1'b0;
         r_prod_clr <= 1'b0;
         r_acc      <= '0;
      end else begin
         r_prod_vld <= i_en;
         r_prod_clr <= i_clr;
         if (i_en) begin
            r_prod <= PROD_W'(i_q) * PROD_W'(i_k);
         end
         if (r_prod_vld) begin
            r_acc <= r_prod_clr ? w_prod_ext : r_acc + w_prod_ext;
         end
      end
   end

endmodule

// File: rtl/qk_score_engine.sv
// Streams scaled, saturated, optionally causal-masked Q·Kᵀ scores, LANES query rows per K row pass.
module qk_score_engine
   import qk_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = QK_DATA_WIDTH,
   parameter int unsigned SEQ_LEN     = 64,
   parameter int unsigned EMBED_DIM   = 64,
   parameter int unsigned FRAC_BITS   = 14,
   parameter int unsigned LANES       = 4,
   parameter int unsigned ACC_WIDTH   = 40,
   parameter int unsigned SCALE_SHIFT = 3
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    start,
   input  logic                                    causal_en,
   input  logic [SEQ_LEN*EMBED_DIM*DATA_WIDTH-1:0] Q_flat,
   qk_score_engine_if.slave                        bus,
   output logic                                    busy,
   output logic                                    done
);
   localparam int unsigned IDX_W  = $clog2(SEQ_LEN);
   localparam int unsigned NGRP   = SEQ_LEN / LANES;
   localparam int unsigned GRP_W  = (NGRP > 1) ? $clog2(NGRP) : 1;
   localparam int unsigned ELEM_W = (EMBED_DIM > 1) ? $clog2(EMBED_DIM) : 1;
   localparam int unsigned QIDX_W = $clog2(SEQ_LEN * EMBED_DIM);

   state_t                          r_state;
   state_t                          w_state_nxt;
   logic                            r_causal;
   logic [IDX_W-1:0]                r_col;
   logic [GRP_W-1:0]                r_grp;
   logic [ELEM_W-1:0]               r_elem;
   logic                            r_drain;
   logic [DATA_WIDTH*EMBED_DIM-1:0] r_k_row;

   logic                            r_k_ready;
   logic                            r_score_valid;
   logic [LANES*DATA_WIDTH-1:0]     r_score_data;
   logic [IDX_W-1:0]                r_score_row;
   logic [IDX_W-1:0]                r_score_col;
   logic                            r_busy;
   logic                            r_done;

   logic                            w_start_run;
   logic                            w_k_fire;
   logic                            w_mac_en;
   logic                            w_mac_clr;
   logic                            w_capture;
   logic                            w_grp_adv;
   logic                            w_col_adv;
   logic                            w_elem_last;
   logic signed [DATA_WIDTH-1:0]    w_k_elem;
   logic signed [DATA_WIDTH-1:0]    w_scores [LANES];

   assign w_elem_last = (r_elem == ELEM_W'(EMBED_DIM - 1));
   assign w_k_elem    = r_k_row[r_elem*DATA_WIDTH +: DATA_WIDTH];

   assign bus.k_ready     = r_k_ready;
   assign bus.score_valid = r_score_valid;
   assign bus.score_data  = r_score_data;
   assign bus.score_row   = r_score_row;
   assign bus.score_col   = r_score_col;
   assign busy            = r_busy;
   assign done            = r_done;

   // Next-state and per-cycle control strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_start_run = 1'b0;
      w_k_fire    = 1'b0;
      w_mac_en    = 1'b0;
      w_mac_clr   = 1'b0;
      w_capture   = 1'b0;
      w_grp_adv   = 1'b0;
      w_col_adv   = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_start_run = 1'b1;
               w_state_nxt = LOAD;
            end
         end
         LOAD: begin
            if (bus.k_valid && r_k_ready) begin
               w_k_fire    = 1'b1;
               w_state_nxt = MAC;
            end
         end
         MAC: begin
            w_mac_en  = 1'b1;
            w_mac_clr = (r_elem == '0);
            if (w_elem_last) begin
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (r_drain) begin
               w_capture   = 1'b1;
               w_state_nxt = OUT;
            end
         end
         OUT: begin
            if (bus.score_ready) begin
               if (r_grp != GRP_W'(NGRP - 1)) begin
                  w_grp_adv   = 1'b1;
                  w_state_nxt = MAC;
               end else if (r_col != IDX_W'(SEQ_LEN - 1)) begin
                  w_col_adv   = 1'b1;
                  w_state_nxt = LOAD;
               end else begin
                  w_state_nxt = DONE;
               end
            end
         end
         DONE: begin
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Counters, K row holding register and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_causal      <= 1'b0;
         r_col         <= '0;
         r_grp         <= '0;
         r_elem        <= '0;
         r_drain       <= 1'b0;
         r_k_row       <= '0;
         r_k_ready     <= 1'b0;
         r_score_valid <= 1'b0;
         r_score_data  <= '0;
         r_score_row   <= '0;
         r_score_col   <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         if (w_start_run) begin
            r_causal <= causal_en;
            r_col    <= '0;
            r_grp    <= '0;
         end
         if (w_grp_adv) begin
            r_grp <= r_grp + 1'b1;
         end
         if (w_col_adv) begin
            r_col <= r_col + 1'b1;
            r_grp <= '0;
         end
         if (w_k_fire) begin
            r_k_row <= bus.k_row;
         end
         if (w_mac_en) begin
            r_elem <= w_elem_last ? '0 : r_elem + 1'b1;
         end
         r_drain <= (r_state == DRAIN) ? ~r_drain : 1'b0;
         if (w_capture) begin
            for (int l = 0; l < LANES; l++) begin
               r_score_data[l*DATA_WIDTH +: DATA_WIDTH] <= w_scores[l];
            end
            r_score_row <= IDX_W'(r_grp * LANES);
            r_score_col <= r_col;
         end
         r_k_ready     <= (w_state_nxt == LOAD);
         r_score_valid <= (w_state_nxt == OUT);
         r_busy        <= (w_state_nxt != IDLE);
         r_done        <= (w_state_nxt == DONE);
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [IDX_W-1:0]             w_qrow;
      logic [QIDX_W-1:0]            w_qidx;
      logic signed [DATA_WIDTH-1:0] w_q_elem;
      logic signed [ACC_WIDTH-1:0]  w_acc;
      logic signed [DATA_WIDTH-1:0] w_score;

      assign w_qrow   = IDX_W'(r_grp * LANES + l);
      assign w_qidx   = QIDX_W'(32'(w_qrow) * EMBED_DIM + 32'(r_elem));
      assign w_q_elem = Q_flat[w_qidx*DATA_WIDTH +: DATA_WIDTH];

      qk_mac_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .FRAC_BITS  (FRAC_BITS),
         .ACC_WIDTH  (ACC_WIDTH)
      ) u_lane (
         .clk   (clk),
         .rst   (rst),
         .i_en  (w_mac_en),
         .i_clr (w_mac_clr),
         .i_q   (w_q_elem),
         .i_k   (w_k_elem),
         .o_acc (w_acc)
      );

      // Keys later than the query row are forced to the most negative score.
      always_comb begin
         w_score = sat_to_data(SAT_IN_WIDTH'(w_acc), SCALE_SHIFT);
         if (r_causal && (r_col > w_qrow)) begin
            w_score = MIN_SCORE;
         end
      end

      assign w_scores[l] = w_score;
   end

endmodule

// File: doc/qk_score_engine.md
# qk_score_engine

Multi-lane, backpressure-aware successor to the single-lane Q·Kᵀ multiplier in the attention datapath. It sits between the K-row source and the softmax stage.
- Holds the full Q matrix on a flat bus and accepts one K row per handshake.
- Computes LANES query dot products in parallel against each K row.
- Scales, saturates and optionally causal-masks each result.
- Streams scores out on a valid/ready interface instead of writing a flat score matrix.

## Interface
- DATA_WIDTH, 16: signed fixed-point element width.
- SEQ_LEN, 64: number of query rows and key rows. Must be divisible by LANES.
- EMBED_DIM, 64: elements per row.
- FRAC_BITS, 14: fractional bits of Q, K and the scores.
- LANES, 4: query rows computed in parallel.
- ACC_WIDTH, 40: accumulator width. Must be ≥ 2*DATA_WIDTH-FRAC_BITS+$clog2(EMBED_DIM).
- SCALE_SHIFT, 3: arithmetic right shift applied to each final sum (1/√d approximation).

Ports:
- clk, in, 1: the only clock.
- rst, in, 1: synchronous, active-high reset.
- start, in, 1: single-cycle pulse that begins a run. Ignored unless the FSM is in IDLE.
- causal_en, in, 1: causal-mask enable. Sampled at start.
- Q_flat, in, SEQ_LEN*EMBED_DIM*DATA_WIDTH: element (r,e) is at bits [(r*EMBED_DIM+e)*DATA_WIDTH +: DATA_WIDTH]. Held stable for the whole run.
- k_valid, in, 1: K row offered.
- k_ready, out, 1: engine can accept a K row.
- k_row, in, DATA_WIDTH*EMBED_DIM: element e is at bits [e*DATA_WIDTH +: DATA_WIDTH].
- score_valid, out, 1: score group available.
- score_ready, in, 1: consumer accepts the score group.
- score_data, out, LANES*DATA_WIDTH: lane l holds the score for query row score_row+l.
- score_row, out, $clog2(SEQ_LEN): first query row of the group.
- score_col, out, $clog2(SEQ_LEN): key index of the group.
- busy, out, 1: high whenever the FSM is not in IDLE.
- done, out, 1: one-cycle pulse at the end of a run.

## Operation
- States and transitions:
  - IDLE → LOAD on start. At that transition, latch causal_en and clear the column and group counters.
  - LOAD: k_ready=1. On k_valid&&k_ready, register k_row and go to MAC.
  - MAC: runs EMBED_DIM cycles, issuing element e=0..EMBED_DIM-1 to every lane. Lane l uses Q row g*LANES+l. Then go to DRAIN.
  - DRAIN: 2 cycles while the multiply and accumulate registers flush. Then go to OUT.
  - OUT: score_valid=1. On score_ready:
    - if the group is not the last, group+1 and go to MAC;
    - else if col<SEQ_LEN-1, col+1, group=0 and go to LOAD;
    - else go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- K rows are numbered 0..SEQ_LEN-1 in acceptance order.
- Per-lane arithmetic:
  - Product: signed DATA_WIDTH×DATA_WIDTH, registered, then arithmetic shift right by FRAC_BITS (floor).
  - The shifted product is sign-extended to ACC_WIDTH and accumulated.
  - The accumulator is cleared at the first element of every group.
- Output conversion: sum >>> SCALE_SHIFT, then saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Never truncate.
- Causal mask: when the latched causal_en=1 and score_col > query row, that lane outputs -2^(DATA_WIDTH-1).
- score_data, score_row and score_col are registered and held stable while score_valid=1 and score_ready=0.
- rst in any state has the following effect:
  - the FSM returns to IDLE;
  - all outputs go low or zero;
  - the counters and accumulators clear;
  - any partial run is discarded with no done pulse.

## Timing
- Reset values: k_ready=0, score_valid=0, score_data=0, score_row=0, score_col=0, busy=0, done=0.
- If the K handshake completes at edge T, the first score_valid is high in the cycle after edge T+EMBED_DIM+2.
- Each subsequent group follows the OUT handshake by EMBED_DIM+2 cycles.
- Minimum run length: SEQ_LEN*(SEQ_LEN/LANES)*(EMBED_DIM+3) cycles plus LOAD handshakes and 1 DONE cycle.
- start while busy=1 has no effect.
- k_ready is never high in the same cycle as score_valid.

## Structure
- Package qk_pkg holds:
  - the state enum (IDLE, LOAD, MAC, DRAIN, OUT, DONE);
  - a sat_to_data function (ACC_WIDTH → DATA_WIDTH, with shift);
  - localparams MIN_SCORE and MAX_SCORE.
- Sub-module qk_mac_lane: one lane containing the registered multiply, the FRAC_BITS shift and the accumulator, with clear and enable inputs. qk_score_engine instantiates it LANES times via generate.

## Test plan
All scenarios use SEQ_LEN=4, EMBED_DIM=4, LANES=2, FRAC_BITS=14, SCALE_SHIFT=0 unless stated.
- Q all 0x1000 (0.25), K all 0x4000 (1.0) → every score 0x4000. Exactly 8 score groups, then a single done pulse.
- Q all 0x4000, K all 0x4000 (sum 4.0) → every score 0x7FFF. Q all 0xC000 (-1.0) with the same K → every score 0x8000 (saturation, no wrap).
- First scenario's data with SCALE_SHIFT=1 → every score 0x2000.
- First scenario's data with causal_en=1 → group (row 0, col 1) yields {0x4000, 0x8000}. Every lane with col>row outputs 0x8000.
- Hold score_ready low for 5 cycles on the first group → score_valid, score_data, score_row and score_col stay constant; no group is lost or duplicated; k_ready stays 0.
- Assert rst for 1 cycle during MAC of column 2 → next cycle busy=0 and score_valid=0, with no done pulse. A new start then produces correct results from column 0.
